// File: rtl/l2_line_responder.sv
// Direct-mapped write-back L2 between the L1 line port and main memory.
// Serves L1 fills and write-backs; evicts dirty victims before refilling.
module l2_line_responder #(
   parameter int INDEX_W = 6,
   parameter int TAG_W   = 28 - INDEX_W
) (
   input  logic         clk,
   input  logic         proc_reset_n,
   input  logic         l1_read,
   input  logic         l1_write,
   input  logic [27:0]  l1_addr,
   input  logic [127:0] l1_wdata,
   output logic [127:0] l1_rdata,
   output logic         l1_ready,
   output logic         mem_read,
   output logic         mem_write,
   output logic [27:0]  mem_addr,
   output logic [127:0] mem_wdata,
   input  logic [127:0] mem_rdata,
   input  logic         mem_ready
);

   localparam int LINES = 1 << INDEX_W;

   typedef enum logic [2:0] {
      IDLE, RESP, COOL, WB, WB_GAP, FILL
   } state_e;

   state_e state_q, state_d;

   logic [LINES-1:0] valid_q, dirty_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [127:0]     data_q [LINES];

   logic [127:0] rdata_q, rdata_d;
   logic         ready_q, ready_d;
   logic         mrd_q, mrd_d;
   logic         mwr_q, mwr_d;
   logic [27:0]  maddr_q, maddr_d;
   logic [127:0] mwdata_q, mwdata_d;

   logic [INDEX_W-1:0] idx;
   logic [TAG_W-1:0]   tag;
   logic               rd, wr, hit, vic_dirty;
   logic               we, we_dirty;
   logic [127:0]       we_data;

   assign idx = l1_addr[INDEX_W-1:0];
   assign tag = l1_addr[27:INDEX_W];
   // read wins when both requests are raised
   assign rd  = l1_read;
   assign wr  = l1_write & ~l1_read;

   assign hit       = valid_q[idx] && (tag_q[idx] == tag);
   assign vic_dirty = valid_q[idx] && dirty_q[idx];

   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) begin
         state_q  <= IDLE;
         valid_q  <= '0;
         dirty_q  <= '0;
         rdata_q  <= '0;
         ready_q  <= 1'b0;
         mrd_q    <= 1'b0;
         mwr_q    <= 1'b0;
         maddr_q  <= '0;
         mwdata_q <= '0;
      end else begin
         state_q  <= state_d;
         rdata_q  <= rdata_d;
         ready_q  <= ready_d;
         mrd_q    <= mrd_d;
         mwr_q    <= mwr_d;
         maddr_q  <= maddr_d;
         mwdata_q <= mwdata_d;
         if (we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= we_dirty;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         tag_q[idx]  <= tag;
         data_q[idx] <= we_data;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (rd) begin
               if (hit)            state_d = RESP;
               else if (vic_dirty) state_d = WB;
               else                state_d = FILL;
            end else if (wr) begin
               if (hit || !vic_dirty) state_d = RESP;
               else                   state_d = WB;
            end
         end
         RESP:   state_d = COOL;
         COOL:   state_d = IDLE;
         WB:     if (mem_ready) state_d = WB_GAP;
         WB_GAP: state_d = rd ? FILL : RESP;
         FILL:   if (mem_ready) state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rdata_d  = rdata_q;
      mrd_d    = mrd_q;
      mwr_d    = mwr_q;
      maddr_d  = maddr_q;
      mwdata_d = mwdata_q;
      we       = 1'b0;
      we_dirty = 1'b0;
      we_data  = l1_wdata;
      unique case (state_q)
         IDLE: begin
            if (rd || wr) begin
               if (hit) begin
                  if (rd) begin
                     rdata_d = data_q[idx];
                  end else begin
                     we       = 1'b1;
                     we_dirty = 1'b1;
                  end
               end else if (vic_dirty) begin
                  mwr_d    = 1'b1;
                  maddr_d  = {tag_q[idx], idx};
                  mwdata_d = data_q[idx];
               end else if (rd) begin
                  mrd_d   = 1'b1;
                  maddr_d = l1_addr;
               end else begin
                  // full-line write miss needs no fetch
                  we       = 1'b1;
                  we_dirty = 1'b1;
               end
            end
         end
         WB: begin
            if (mem_ready) mwr_d = 1'b0;
         end
         WB_GAP: begin
            if (rd) begin
               mrd_d   = 1'b1;
               maddr_d = l1_addr;
            end else begin
               we       = 1'b1;
               we_dirty = 1'b1;
            end
         end
         FILL: begin
            if (mem_ready) begin
               we      = 1'b1;
               we_data = mem_rdata;
               rdata_d = mem_rdata;
               mrd_d   = 1'b0;
            end
         end
         default: ;
      endcase
      ready_d = (state_d == RESP);
   end

   assign l1_rdata  = rdata_q;
   assign l1_ready  = ready_q;
   assign mem_read  = mrd_q;
   assign mem_write = mwr_q;
   assign mem_addr  = maddr_q;
   assign mem_wdata = mwdata_q;

endmodule

// File: tb/tb_l2_line_responder.sv
// Bench for l2_line_responder: L1 driver, memory responder and a
// cache/memory reference model checked every cycle of each transaction.
module tb_l2_line_responder;

   logic         clk = 1'b0;
   logic         proc_reset_n;
   logic         l1_read, l1_write;
   logic [27:0]  l1_addr;
   logic [127:0] l1_wdata, l1_rdata;
   logic         l1_ready;
   logic         mem_read, mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata, mem_rdata;
   logic         mem_ready;

   l2_line_responder dut (
      .clk          (clk),
      .proc_reset_n (proc_reset_n),
      .l1_read      (l1_read),
      .l1_write     (l1_write),
      .l1_addr      (l1_addr),
      .l1_wdata     (l1_wdata),
      .l1_rdata     (l1_rdata),
      .l1_ready     (l1_ready),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // downstream memory contents and the value the L1 must observe
   logic [127:0] dmem [logic [27:0]];
   logic [127:0] refm [logic [27:0]];
   bit           m_valid [64];
   bit           m_dirty [64];
   logic [21:0]  m_tag   [64];
   logic [127:0] last_rd;
   int           mdelay;

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] init_val(input logic [27:0] a);
      logic [31:0] w;
      w = {4'h0, a} ^ 32'h9e3779b9;
      return {w, ~w, w + 32'd7, w ^ 32'h5a5a0000};
   endfunction

   function automatic logic [127:0] dval(input logic [27:0] a);
      return dmem.exists(a) ? dmem[a] : init_val(a);
   endfunction

   function automatic logic [127:0] rval(input logic [27:0] a);
      return refm.exists(a) ? refm[a] : init_val(a);
   endfunction

   task automatic txn(input bit rd, input bit both, input logic [27:0] a,
                      input logic [127:0] wd);
      int           i, cyc, rdy_cyc, mr_cyc, wbr_cyc, rs_cyc, ws_cyc;
      int           wseen, rseen, cnt;
      bit           pend, pend_wr, hit, exp_wb, exp_fill;
      logic [27:0]  paddr, wb_addr;
      logic [127:0] wb_data;
      i = int'(a[5:0]);
      hit      = m_valid[i] && (m_tag[i] == a[27:6]);
      exp_wb   = !hit && m_valid[i] && m_dirty[i];
      exp_fill = rd && !hit;
      wb_addr  = {m_tag[i], a[5:0]};
      wb_data  = rval(wb_addr);
      cyc = 0; rdy_cyc = -1; mr_cyc = -1; wbr_cyc = -1;
      rs_cyc = -1; ws_cyc = -1; wseen = 0; rseen = 0; cnt = 0;
      pend = 0; pend_wr = 0; paddr = '0;
      l1_read  = rd;
      l1_write = !rd || both;
      l1_addr  = a;
      l1_wdata = wd;
      while (rdy_cyc < 0 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         mem_ready = 1'b0;
         if (l1_ready) rdy_cyc = cyc;
         if (mem_read && mem_write) chk("mem_excl", 1, 0);
         if (!pend && (mem_read || mem_write)) begin
            pend = 1; pend_wr = mem_write; paddr = mem_addr;
            cnt = mdelay;
            if (mem_write) begin
               wseen++; ws_cyc = cyc;
               chk("wb_addr", mem_addr, wb_addr);
               chk("wb_data", mem_wdata, wb_data);
            end else begin
               rseen++; rs_cyc = cyc;
               chk("fill_addr", mem_addr, a);
            end
         end else if (pend) begin
            if ({mem_read, mem_write, mem_addr} !==
                {!pend_wr, pend_wr, paddr})
               chk("mem_hold", {mem_read, mem_write, mem_addr},
                   {!pend_wr, pend_wr, paddr});
         end
         if (pend) begin
            if (cnt == 0) begin
               mem_ready = 1'b1;
               pend = 0;
               if (pend_wr) begin
                  dmem[paddr] = mem_wdata;
                  wbr_cyc = cyc;
               end else begin
                  mem_rdata = dval(paddr);
                  mr_cyc = cyc;
               end
            end else cnt--;
         end
      end
      if (rdy_cyc < 0) begin
         chk("timeout", 0, 1);
         mem_ready = 1'b0;
         return;
      end
      chk("wb_count", wseen, exp_wb);
      chk("fill_count", rseen, exp_fill);
      if (!exp_wb && !exp_fill) chk("lat1", rdy_cyc, 1);
      if (exp_wb) chk("wb_start", ws_cyc, 1);
      if (exp_fill && !exp_wb) chk("fill_start", rs_cyc, 1);
      if (exp_fill) chk("fill_to_ready", rdy_cyc, mr_cyc + 1);
      if (exp_wb && exp_fill) chk("wb_gap_rd", rs_cyc, wbr_cyc + 2);
      if (exp_wb && !rd) chk("wb_gap_wr", rdy_cyc, wbr_cyc + 2);
      if (rd) begin
         chk("rdata", l1_rdata, rval(a));
         last_rd = l1_rdata;
      end else begin
         chk("rdata_keep", l1_rdata, last_rd);
      end
      if (!rd) refm[a] = wd;
      if (!hit) begin
         m_valid[i] = 1;
         m_tag[i]   = a[27:6];
         m_dirty[i] = 0;
      end
      if (!rd) m_dirty[i] = 1;
      // L1 still holds its request through the cool-down cycle
      @(negedge clk);
      chk("cool_quiet", {l1_ready, mem_read, mem_write}, 0);
      l1_read  = 1'b0;
      l1_write = 1'b0;
      @(negedge clk);
      chk("idle_quiet", {l1_ready, mem_read, mem_write}, 0);
   endtask

   initial begin
      logic [27:0] a;
      int k;
      proc_reset_n = 1'b0;
      l1_read = 0; l1_write = 0; l1_addr = '0; l1_wdata = '0;
      mem_rdata = '0; mem_ready = 0;
      last_rd = '0;
      mdelay = 2;
      for (int i = 0; i < 64; i++) begin
         m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0;
      end
      repeat (3) @(negedge clk);
      chk("rst_outs", {l1_ready, mem_read, mem_write, mem_addr}, 0);
      chk("rst_rdata", l1_rdata, 0);
      chk("rst_wdata", mem_wdata, 0);
      proc_reset_n = 1'b1;
      @(negedge clk);

      dmem[28'h0000040] = {16{8'hA5}};
      refm[28'h0000040] = {16{8'hA5}};
      txn(1, 0, 28'h0000040, '0);
      chk("pin_fill_a5", l1_rdata, {16{8'hA5}});
      txn(1, 0, 28'h0000040, '0);
      chk("pin_hit_a5", l1_rdata, {16{8'hA5}});
      txn(0, 0, 28'h0000040, {32{4'h1}});
      txn(1, 0, 28'h0000080, '0);
      chk("pin_wb_mem", dmem[28'h0000040], {32{4'h1}});
      txn(0, 0, 28'h0000005, {32{4'h2}});
      txn(1, 0, 28'h0000005, '0);
      chk("pin_wmiss_hit", l1_rdata, {32{4'h2}});
      txn(1, 1, 28'h0000005, {32{4'h7}});
      chk("pin_both_read", l1_rdata, {32{4'h2}});

      for (int n = 0; n < 300; n++) begin
         bit rd;
         rd = 1'($urandom_range(0, 1));
         a = 28'(($urandom_range(0, 3) << 6) | $urandom_range(0, 3));
         mdelay = $urandom_range(0, 3);
         txn(rd, rd && ($urandom_range(0, 7) == 0), a,
             {$urandom, $urandom, $urandom, $urandom});
      end

      // reset during a fill: abort, lose contents, 0x40 misses again
      l1_read = 1'b1; l1_write = 1'b0; l1_addr = 28'h000017f;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!mem_read && k < 10);
      chk("fill_started", mem_read, 1);
      #2 proc_reset_n = 1'b0;
      #1;
      chk("rst_async", {mem_read, l1_ready, mem_write}, 0);
      l1_read = 1'b0;
      repeat (2) @(negedge clk);
      proc_reset_n = 1'b1;
      for (int i = 0; i < 64; i++) begin
         m_valid[i] = 0; m_dirty[i] = 0;
      end
      refm = dmem;
      last_rd = '0;
      mdelay = 1;
      txn(1, 0, 28'h0000040, '0);
      for (int n = 0; n < 40; n++) begin
         bit rd;
         rd = 1'($urandom_range(0, 1));
         a = 28'(($urandom_range(0, 3) << 6) | $urandom_range(0, 3));
         mdelay = $urandom_range(0, 3);
         txn(rd, 0, a, {$urandom, $urandom, $urandom, $urandom});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
